// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, HI/LO
// read-select values, FSM states and the packed HI/LO result type.
package mul_div_unit_pkg;

    // Operation codes carried on MDOpE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Values of HiLoSelE for mfhi / mflo.
    localparam logic HILO_SEL_HI = 1'b1;
    localparam logic HILO_SEL_LO = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage connection between the datapath/hazard logic (master) and
// the multiply/divide unit (slave).
interface mul_div_unit_if;
    logic [31:0] AE;
    logic [31:0] BE;
    logic [2:0]  MDOpE;
    logic        HiLoSelE;
    logic        MDUseD;
    logic [31:0] MDOutE;
    logic        Busy;
    logic        MDStall;

    modport master (
        output AE, BE, MDOpE, HiLoSelE, MDUseD,
        input  MDOutE, Busy, MDStall
    );

    modport slave (
        input  AE, BE, MDOpE, HiLoSelE, MDUseD,
        output MDOutE, Busy, MDStall
    );
endinterface

// File: rtl/mul_div_unit_md_arith.sv
// Combinational arithmetic core: produces the full {hi, lo} result of the
// operation presented in E, plus a divide-by-zero flag for div/divu.
module md_arith
    import mul_div_unit_pkg::*;
(
    input  logic [31:0] i_ae,
    input  logic [31:0] i_be,
    input  logic [2:0]  i_md_op,
    output hilo_t       o_result,
    output logic        o_divzero
);

    logic               w_be_zero;
    logic [31:0]        w_be_safe;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;

    // A zero divisor is swapped for 1 so the dividers never see x/0; the
    // result is discarded at retirement anyway.
    assign w_be_zero = (i_be == 32'd0);
    assign w_be_safe = w_be_zero ? 32'd1 : i_be;

    assign w_prod_s = $signed({{32{i_ae[31]}}, i_ae}) * $signed({{32{i_be[31]}}, i_be});
    assign w_prod_u = {32'd0, i_ae} * {32'd0, i_be};

    // Signed / and % truncate toward zero; the remainder follows the dividend.
    assign w_quo_s = $signed(i_ae) / $signed(w_be_safe);
    assign w_rem_s = $signed(i_ae) % $signed(w_be_safe);
    assign w_quo_u = i_ae / w_be_safe;
    assign w_rem_u = i_ae % w_be_safe;

    // Select the result for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_result  = '0;
        o_divzero = 1'b0;
        case (i_md_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV: begin
                o_result.hi = w_rem_s;
                o_result.lo = w_quo_s;
                o_divzero   = w_be_zero;
            end
            MD_DIVU: begin
                o_result.hi = w_rem_u;
                o_result.lo = w_quo_u;
                o_divzero   = w_be_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at
// launch and held as pending until the busy countdown expires, at which
// point they become architectural. Raises MDStall for HI/LO users in D.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic            clk,
    input logic            reset,
    mul_div_unit_if.slave  md
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    hilo_t            r_pend;
    logic             r_pend_dz;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;

    hilo_t            w_result;
    logic             w_divzero;
    logic             w_start;

    md_arith u_arith (
        .i_ae      (md.AE),
        .i_be      (md.BE),
        .i_md_op   (md.MDOpE),
        .o_result  (w_result),
        .o_divzero (w_divzero)
    );

    assign w_start = !r_busy && is_start_op(md.MDOpE);

    // Launch, count down and retire operations; handle mthi/mtlo when idle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pend    <= w_result;
                        r_pend_dz <= w_divzero;
                        r_cnt     <= is_div_op(md.MDOpE) ? CNT_W'(DIV_CYCLES)
                                                         : CNT_W'(MUL_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end else if (md.MDOpE == MD_MTHI) begin
                        r_hi <= md.AE;
                    end else if (md.MDOpE == MD_MTLO) begin
                        r_lo <= md.AE;
                    end
                end
                ST_BUSY: begin
                    // Any MDOpE arriving here is ignored; only the countdown advances.
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_pend_dz) begin
                            r_hi <= r_pend.hi;
                            r_lo <= r_pend.lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Architectural read path and stall request.
    assign md.MDOutE  = (md.HiLoSelE == HILO_SEL_HI) ? r_hi : r_lo;
    assign md.Busy    = r_busy;
    assign md.MDStall = md.MDUseD && (w_start || r_busy);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes per-cycle expectations
// into a queue, a monitor on the falling edge pops and compares them.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef enum int { F_OUT, F_BUSY, F_STALL } field_e;
    typedef struct {
        int          cyc;
        field_e      f;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t q[$];

    mul_div_unit_if md_if ();

    mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs just after the rising edge.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sel, input logic use_d, input logic rst);
        @(posedge clk);
        #1;
        md_if.MDOpE    = op;
        md_if.AE       = a;
        md_if.BE       = b;
        md_if.HiLoSelE = sel;
        md_if.MDUseD   = use_d;
        reset          = rst;
    endtask

    // Queue the expected outputs for the current cycle.
    task automatic expect_now(input string name, input logic busy, input logic stall,
                              input logic [31:0] out);
        exp_t e;
        e.cyc = cyc; e.name = name;
        e.f = F_BUSY;  e.val = {31'd0, busy};  q.push_back(e);
        e.f = F_STALL; e.val = {31'd0, stall}; q.push_back(e);
        e.f = F_OUT;   e.val = out;            q.push_back(e);
    endtask

    // Launch a multi-cycle op, walk through its busy window, then read HI and LO.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_d, input int k,
                          input logic [31:0] old_hi, input logic [31:0] new_hi,
                          input logic [31:0] new_lo);
        step(op, a, b, HILO_SEL_HI, use_d, 1'b1);
        expect_now({name, "_launch"}, 1'b0, use_d, old_hi);
        for (int i = 1; i <= k; i++) begin
            step(MD_NONE, 32'd0, 32'd0, HILO_SEL_HI, use_d, 1'b1);
            expect_now($sformatf("%s_busy%0d", name, i), 1'b1, use_d, old_hi);
        end
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_HI, use_d, 1'b1);
        expect_now({name, "_hi"}, 1'b0, 1'b0, new_hi);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now({name, "_lo"}, 1'b0, 1'b0, new_lo);
    endtask

    // Monitor: compare every expectation due in this cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        n_checks = 0;
        n_pass   = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                case (e.f)
                    F_BUSY:  act = {31'd0, md_if.Busy};
                    F_STALL: act = {31'd0, md_if.MDStall};
                    default: act = md_if.MDOutE;
                endcase
                n_checks++;
                if (e.cyc != cyc)
                    $display("FAIL %s field %s: expectation for cycle %0d seen at cycle %0d",
                             e.name, e.f.name(), e.cyc, cyc);
                else if (act === e.val)
                    n_pass++;
                else
                    $display("FAIL %s field %s: got %08h, expected %08h",
                             e.name, e.f.name(), act, e.val);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        reset          = 1'b0;
        md_if.MDOpE    = MD_NONE;
        md_if.AE       = '0;
        md_if.BE       = '0;
        md_if.HiLoSelE = HILO_SEL_HI;
        md_if.MDUseD   = 1'b0;

        // Reset state: all clear, no stall even with a D-stage user.
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_HI, 1'b1, 1'b0);
        expect_now("rst_hi", 1'b0, 1'b0, 32'd0);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b1, 1'b1);
        expect_now("rst_lo", 1'b0, 1'b0, 32'd0);

        // mult 3 * -2 with a HI/LO user held in D throughout.
        run_op("mult", MD_MULT, 32'd3, 32'hFFFF_FFFE, 1'b1, 5,
               32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFF * 2, no user in D: MDStall stays low.
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 5,
               32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

        // div -7 / 2: quotient -3, remainder -1.
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 10,
               32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // mthi / mtlo preload, single cycle, never busy.
        step(MD_MTHI, 32'h11, 32'd0, HILO_SEL_HI, 1'b0, 1'b1);
        expect_now("mthi11_issue", 1'b0, 1'b0, 32'hFFFF_FFFF);
        step(MD_MTLO, 32'h22, 32'd0, HILO_SEL_HI, 1'b0, 1'b1);
        expect_now("mtlo22_issue", 1'b0, 1'b0, 32'h11);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("mtlo22_read", 1'b0, 1'b0, 32'h22);

        // divu by zero: full busy window, HI/LO untouched.
        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 1'b0, 10,
               32'h11, 32'h11, 32'h22);

        // mthi then mfhi / mflo.
        step(MD_MTHI, 32'hDEAD_BEEF, 32'd0, HILO_SEL_HI, 1'b0, 1'b1);
        expect_now("mthi_issue", 1'b0, 1'b0, 32'h11);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_HI, 1'b0, 1'b1);
        expect_now("mfhi", 1'b0, 1'b0, 32'hDEAD_BEEF);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("mflo", 1'b0, 1'b0, 32'h22);

        // mult 2*3 with an mtlo injected mid-flight: ignored, countdown intact.
        step(MD_MULT, 32'd2, 32'd3, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("inj_launch", 1'b0, 1'b0, 32'h22);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("inj_busy1", 1'b1, 1'b0, 32'h22);
        step(MD_MTLO, 32'h55, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("inj_busy2", 1'b1, 1'b0, 32'h22);
        for (int i = 3; i <= 5; i++) begin
            step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
            expect_now($sformatf("inj_busy%0d", i), 1'b1, 1'b0, 32'h22);
        end
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("inj_lo", 1'b0, 1'b0, 32'd6);
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_HI, 1'b0, 1'b1);
        expect_now("inj_hi", 1'b0, 1'b0, 32'd0);

        // div 100 / 7 abandoned by reset in its 4th busy cycle.
        step(MD_DIV, 32'd100, 32'd7, HILO_SEL_LO, 1'b0, 1'b1);
        expect_now("rdiv_launch", 1'b0, 1'b0, 32'd6);
        for (int i = 1; i <= 3; i++) begin
            step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b1);
            expect_now($sformatf("rdiv_busy%0d", i), 1'b1, 1'b0, 32'd6);
        end
        step(MD_NONE, 32'd0, 32'd0, HILO_SEL_LO, 1'b0, 1'b0);
        expect_now("rdiv_busy4", 1'b1, 1'b0, 32'd6);
        for (int i = 0; i < 14; i++) begin
            step(MD_NONE, 32'd0, 32'd0, i[0], 1'b1, 1'b1);
            expect_now($sformatf("rdiv_after%0d", i), 1'b0, 1'b0, 32'd0);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", q.size());
            n_checks += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers for mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- It is the source side of the stall protocol: it raises a stall request that the hazard controller ORs into StallF/StallD/FlushE.
- A stalled HI/LO user in D stays frozen until the unit retires the operation.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (must be at least 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- AE  in  32  forwarded rs operand in E.
- BE  in  32  forwarded rt operand in E.
- MDOpE  in  3  operation in E, encoded with the `MD_* constants.
- HiLoSelE  in  1  mfhi/mflo read select; 1 selects HI, 0 selects LO.
- MDUseD  in  1  the instruction in D is any HI/LO-class instruction.
- MDOutE  out  32  HI or LO value as chosen by HiLoSelE; combinational.
- Busy  out  1  a multi-cycle operation is in flight.
- MDStall  out  1  stall request to the hazard controller.

Behaviour:
- Reset: when reset is low at a rising edge, HI, LO, Busy, the counter and the pending results all clear to 0. Reset abandons any in-flight operation, and HI/LO stay 0.
- Start: Start = MDOpE is one of mult, multu, div or divu. It is combinational and valid only while Busy is 0.
- Operation launch, at the edge where Start is 1 (cycle N):
  - Latch the full 64-bit result into PendHi/PendLo.
  - Load the counter with MUL_CYCLES or DIV_CYCLES as appropriate.
  - Set Busy.
- States: IDLE and BUSY.
  - IDLE to BUSY on Start.
  - In BUSY, the counter decrements by 1 every edge.
  - At the edge where the counter equals 1: HI takes PendHi, LO takes PendLo, Busy clears and the state returns to IDLE.
- Timing: Busy is high for exactly MUL_CYCLES or DIV_CYCLES cycles, N+1 through N+K. The new HI/LO are visible on MDOutE from cycle N+K+1.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product.
  - multu: unsigned 32x32 to 64-bit product.
  - HI receives the upper 32 bits, LO the lower 32.
  - div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero: the operation still runs the full DIV_CYCLES of Busy, but HI and LO remain unchanged at retirement.
- mthi/mtlo: single cycle, accepted only while Busy is 0. HI (or LO) takes AE at the next edge, and Busy is not asserted.
- MDOp while Busy: the hazard contract guarantees no HI/LO instruction reaches E while Busy is set. If an MDOpE other than none does appear while Busy, the unit ignores it and leaves the in-flight operation and the counter undisturbed.
- MDStall = MDUseD and (Start or Busy).
  - Stalling on Start as well as Busy covers the back-to-back case (launch in E, HI/LO use in D).
  - MDStall is independent of any other stall source.
- Read path: MDOutE always returns the architectural HI/LO, never the pending values. An mfhi/mflo in E reads the committed registers because any producer in flight stalled it in D.

Decomposition:
- The const.v additions:
  - `MD_NONE=0, `MD_MULT=1, `MD_MULTU=2, `MD_DIV=3, `MD_DIVU=4, `MD_MTHI=5, `MD_MTLO=6.
  - `HILO_SEL_HI=1, `HILO_SEL_LO=0.
- One combinational sub-module, md_arith. It takes AE, BE and MDOpE and returns the 64-bit {hi, lo} result plus a divzero flag.
- The mul_div_unit itself holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- mult, AE=3, BE=0xFFFFFFFE, MUL_CYCLES=5 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MDOutE changes no earlier than cycle N+6.
- multu, AE=0xFFFFFFFF, BE=2 -> HI=0x00000001, LO=0xFFFFFFFE. Also run div, AE=0xFFFFFFF9 (-7), BE=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, AE=7, BE=0, with HI=0x11, LO=0x22 beforehand -> Busy high for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Hold MDUseD=1 from the launch cycle through retirement -> MDStall=1 on the launch cycle and all 5 busy cycles (mult), and 0 in the cycle after Busy falls. With MDUseD=0 throughout, MDStall stays 0.
- mthi AE=0xDEADBEEF, then mflo/mfhi -> next cycle HiLoSelE=1 gives MDOutE=0xDEADBEEF and Busy stays 0. Also inject mtlo while Busy -> LO is not modified.
- Launch div, then drive reset low in the 4th busy cycle -> next edge gives Busy=0, HI=0 and LO=0, and no late commit occurs afterwards.
